// File: rtl/pc_npc_sequencer.sv
// PC/nPC fetch sequencer with SPARC delayed control transfer, delay-slot annulment,
// trap redirection and a one-entry buffer for branch resolutions that arrive while fetch stalls.
module pc_npc_sequencer #(
    parameter int WIDTH    = 32,
    parameter int INC      = 4,
    parameter int RESET_PC = 0,
    parameter bit DELAYED  = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Adv,
    input  logic             BrValid,
    output logic             BrReady,
    input  logic             BrTaken,
    input  logic             BrAnnul,
    input  logic [WIDTH-1:0] BrTarget,
    input  logic             Trap,
    input  logic [WIDTH-1:0] TrapVec,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] nPC,
    output logic             Annulled,
    output logic             Pending
);

    localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_PC);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] npc_q, npc_d;
    logic             annulled_q, annulled_d;
    logic             pending_q, pending_d;
    logic             br_ready_q, br_ready_d;
    logic             p_taken_q, p_taken_d;
    logic             p_annul_q, p_annul_d;
    logic [WIDTH-1:0] p_target_q, p_target_d;

    logic             eff_valid_s;
    logic             eff_taken_s;
    logic             eff_annul_s;
    logic [WIDTH-1:0] eff_target_s;
    logic             accept_s;

    // Select the branch seen at this edge: the buffered one wins over the live inputs.
    always_comb begin
        eff_valid_s  = pending_q | BrValid;
        accept_s     = BrValid & ~pending_q;
        if (pending_q) begin
            eff_taken_s  = p_taken_q;
            eff_annul_s  = p_annul_q;
            eff_target_s = p_target_q;
        end else begin
            eff_taken_s  = BrTaken;
            eff_annul_s  = BrAnnul;
            eff_target_s = BrTarget;
        end
    end

    // Next-state: trap, then advance (branch or sequential), then capture, then hold.
    always_comb begin
        pc_d       = pc_q;
        npc_d      = npc_q;
        annulled_d = annulled_q;
        pending_d  = pending_q;
        p_taken_d  = p_taken_q;
        p_annul_d  = p_annul_q;
        p_target_d = p_target_q;
        if (Trap) begin
            pc_d       = TrapVec;
            npc_d      = TrapVec + INC_W;
            annulled_d = 1'b0;
            pending_d  = 1'b0;
        end else if (Adv) begin
            pending_d = 1'b0;
            if (eff_valid_s && eff_taken_s) begin
                annulled_d = 1'b0;
                if (DELAYED) begin
                    pc_d  = npc_q;
                    npc_d = eff_target_s;
                end else begin
                    pc_d  = eff_target_s;
                    npc_d = eff_target_s + INC_W;
                end
            end else begin
                // Untaken annulling branch squashes the delay slot only in delayed mode.
                pc_d       = npc_q;
                npc_d      = npc_q + INC_W;
                annulled_d = eff_valid_s & eff_annul_s & DELAYED;
            end
        end else if (accept_s) begin
            pending_d  = 1'b1;
            p_taken_d  = BrTaken;
            p_annul_d  = BrAnnul;
            p_target_d = BrTarget;
        end else begin
            pending_d = pending_q;
        end
        br_ready_d = ~pending_d;
    end

    // Architectural state and buffered branch, cleared asynchronously.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q       <= RST_PC;
            npc_q      <= RST_PC + INC_W;
            annulled_q <= 1'b0;
            pending_q  <= 1'b0;
            br_ready_q <= 1'b1;
            p_taken_q  <= 1'b0;
            p_annul_q  <= 1'b0;
            p_target_q <= '0;
        end else begin
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            annulled_q <= annulled_d;
            pending_q  <= pending_d;
            br_ready_q <= br_ready_d;
            p_taken_q  <= p_taken_d;
            p_annul_q  <= p_annul_d;
            p_target_q <= p_target_d;
        end
    end

    assign PC       = pc_q;
    assign nPC      = npc_q;
    assign Annulled = annulled_q;
    assign Pending  = pending_q;
    assign BrReady  = br_ready_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Directed bench: three sequencer instances (delayed, immediate, 8-bit) share one stimulus stream.
module tb_pc_npc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Adv, BrValid, BrTaken, BrAnnul, Trap;
    logic [31:0] BrTarget, TrapVec;

    logic [31:0] pc_a, npc_a, pc_b, npc_b;
    logic [7:0]  pc_c, npc_c;
    logic        rdy_a, ann_a, pend_a, rdy_b, ann_b, pend_b, rdy_c, ann_c, pend_c;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pc_npc_sequencer #(.WIDTH(32), .INC(4), .RESET_PC(0), .DELAYED(1'b1)) dut_a (
        .Clk(Clk), .Reset(Reset), .Adv(Adv), .BrValid(BrValid), .BrReady(rdy_a),
        .BrTaken(BrTaken), .BrAnnul(BrAnnul), .BrTarget(BrTarget), .Trap(Trap),
        .TrapVec(TrapVec), .PC(pc_a), .nPC(npc_a), .Annulled(ann_a), .Pending(pend_a));

    pc_npc_sequencer #(.WIDTH(32), .INC(4), .RESET_PC(0), .DELAYED(1'b0)) dut_b (
        .Clk(Clk), .Reset(Reset), .Adv(Adv), .BrValid(BrValid), .BrReady(rdy_b),
        .BrTaken(BrTaken), .BrAnnul(BrAnnul), .BrTarget(BrTarget), .Trap(Trap),
        .TrapVec(TrapVec), .PC(pc_b), .nPC(npc_b), .Annulled(ann_b), .Pending(pend_b));

    pc_npc_sequencer #(.WIDTH(8), .INC(4), .RESET_PC(0), .DELAYED(1'b1)) dut_c (
        .Clk(Clk), .Reset(Reset), .Adv(Adv), .BrValid(BrValid), .BrReady(rdy_c),
        .BrTaken(BrTaken), .BrAnnul(BrAnnul), .BrTarget(BrTarget[7:0]), .Trap(Trap),
        .TrapVec(TrapVec[7:0]), .PC(pc_c), .nPC(npc_c), .Annulled(ann_c), .Pending(pend_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic adv, input logic bv, input logic bt, input logic ba,
                         input logic [31:0] tgt, input logic trap, input logic [31:0] vec);
        Adv = adv; BrValid = bv; BrTaken = bt; BrAnnul = ba; BrTarget = tgt;
        Trap = trap; TrapVec = vec;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Adv = 1'b0; BrValid = 1'b0; BrTaken = 1'b0; BrAnnul = 1'b0;
        BrTarget = 32'h0; Trap = 1'b0; TrapVec = 32'h0;
        #3;
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_npc", npc_a, 32'h4);
        chk("rst_ann", {31'd0, ann_a}, 32'd0);
        chk("rst_pend", {31'd0, pend_a}, 32'd0);
        chk("rst_rdy", {31'd0, rdy_a}, 32'd1);
        @(posedge Clk);
        #1 Reset = 1'b0;

        // Sequential fetch
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("seq_pc", pc_a, 32'(4 * i));
            chk("seq_npc", npc_a, 32'(4 * i + 4));
            chk("seq_ann", {31'd0, ann_a}, 32'd0);
        end

        // Trap to 0x100, then taken branch to 0x200
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
        chk("trap_pc", pc_a, 32'h100);
        chk("trap_npc", npc_a, 32'h104);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0);
        chk("br_dly_pc", pc_a, 32'h104);
        chk("br_dly_npc", npc_a, 32'h200);
        chk("br_imm_pc", pc_b, 32'h200);
        chk("br_imm_npc", npc_b, 32'h204);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("br_dly_pc2", pc_a, 32'h200);
        chk("br_dly_npc2", npc_a, 32'h204);
        chk("br_imm_pc2", pc_b, 32'h204);

        // Untaken annulled branch at 0x100
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
        chk("annul_pc", pc_a, 32'h104);
        chk("annul_npc", npc_a, 32'h108);
        chk("annul_flag", {31'd0, ann_a}, 32'd1);
        chk("annul_imm_flag", {31'd0, ann_b}, 32'd0);
        chk("annul_imm_pc", pc_b, 32'h104);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("annul_pc2", pc_a, 32'h108);
        chk("annul_flag2", {31'd0, ann_a}, 32'd0);

        // Stalled branch capture, second branch ignored, consumed on Adv
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 1'b0, 32'h0);
        chk("cap_pend", {31'd0, pend_a}, 32'd1);
        chk("cap_rdy", {31'd0, rdy_a}, 32'd0);
        chk("cap_pc", pc_a, 32'h108);
        chk("cap_npc", npc_a, 32'h10c);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 1'b0, 32'h0);
        chk("ign_pend", {31'd0, pend_a}, 32'd1);
        chk("ign_pc", pc_a, 32'h108);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 1'b0, 32'h0);
        chk("use_pc", pc_a, 32'h10c);
        chk("use_npc", npc_a, 32'h300);
        chk("use_pend", {31'd0, pend_a}, 32'd0);
        chk("use_rdy", {31'd0, rdy_a}, 32'd1);
        chk("use_imm_pc", pc_b, 32'h300);

        // Trap while a branch is pending and Adv is high
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h500, 1'b0, 32'h0);
        chk("cap2_pend", {31'd0, pend_a}, 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h600, 1'b1, 32'h80);
        chk("tp_pc", pc_a, 32'h80);
        chk("tp_npc", npc_a, 32'h84);
        chk("tp_pend", {31'd0, pend_a}, 32'd0);
        chk("tp_ann", {31'd0, ann_a}, 32'd0);

        // 8-bit wrap-around
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hf8);
        chk("w8_pc0", {24'd0, pc_c}, 32'hf8);
        chk("w8_npc0", {24'd0, npc_c}, 32'hfc);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("w8_pc1", {24'd0, pc_c}, 32'hfc);
        chk("w8_npc1", {24'd0, npc_c}, 32'h00);
        chk("w32_npc1", npc_a, 32'h100);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("w8_pc2", {24'd0, pc_c}, 32'h00);
        chk("w8_npc2", {24'd0, npc_c}, 32'h04);

        // Asynchronous reset between edges, overriding a held branch and a trap
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h900, 1'b0, 32'h0);
        chk("pre_rst_pend", {31'd0, pend_a}, 32'd1);
        Trap = 1'b1; TrapVec = 32'h40;
        #2 Reset = 1'b1;
        #1;
        chk("mid_rst_pc", pc_a, 32'h0);
        chk("mid_rst_npc", npc_a, 32'h4);
        chk("mid_rst_pend", {31'd0, pend_a}, 32'd0);
        chk("mid_rst_rdy", {31'd0, rdy_a}, 32'd1);
        chk("mid_rst_w8", {24'd0, pc_c}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_npc_sequencer.md
Name: pc_npc_sequencer

Overview:
- Parametrised PC/nPC sequencer for the SPARC datapath fetch stage; successor to the plain +4/+8 next-PC adder.
- Holds the architectural PC and nPC registers and advances them one instruction per fetch handshake.
- Supports SPARC delayed control transfer, branch annulment of the delay slot, and trap redirection.
- Buffers one branch resolution that arrives while fetch is stalled.

Parameters:
- WIDTH, 32: address width in bits; all PC arithmetic is modulo 2^WIDTH.
- INC, 4: instruction size in bytes; sequential increment.
- RESET_PC, 0: PC value loaded on reset.
- DELAYED, 1: 1 = SPARC delayed-branch semantics; 0 = immediate redirect, no delay slot.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- Adv  input  1  fetch accepts the current PC; sequencer advances at this edge.
- BrValid  input  1  branch resolution present this cycle.
- BrReady  output  1  branch input can be accepted; equals !Pending.
- BrTaken  input  1  resolved branch is taken.
- BrAnnul  input  1  annul bit of the branch instruction.
- BrTarget  input  WIDTH  branch target address.
- Trap  input  1  trap request, one-cycle pulse.
- TrapVec  input  WIDTH  trap handler address.
- PC  output  WIDTH  current fetch address (registered).
- nPC  output  WIDTH  next fetch address (registered).
- Annulled  output  1  the instruction at PC is a squashed delay slot; fetch must not execute it.
- Pending  output  1  a buffered branch resolution is held.

Behaviour:
- Interface decision: one clock, Clk; reset is asynchronous and active-high, Reset.
- Reset values (asynchronous): PC=RESET_PC, nPC=RESET_PC+INC, Annulled=0, Pending=0, BrReady=1; the pending buffer is cleared.
- All outputs are registered; an update is visible the cycle after the triggering edge.
- Branch accept: a branch is accepted when BrValid=1 and BrReady=1. BrValid while BrReady=0 is ignored; the producer must hold it.
- Effective branch at an Adv edge: the pending buffer if Pending=1, otherwise the live inputs if BrValid=1, otherwise none.
- Priority at each edge: Trap, then Adv with an effective branch, then Adv sequential, then hold/capture.
- Trap=1 (Adv ignored): PC<=TrapVec, nPC<=TrapVec+INC, Annulled<=0, Pending<=0. The buffered branch and any live BrValid are discarded.
- Adv=1, taken branch, DELAYED=1: PC<=nPC, nPC<=BrTarget, Annulled<=0.
- Adv=1, taken branch, DELAYED=0: PC<=BrTarget, nPC<=BrTarget+INC, Annulled<=0.
- Adv=1, untaken branch with BrAnnul=1: PC<=nPC, nPC<=nPC+INC, Annulled<=1 (delay slot squashed). With DELAYED=0 this is treated as sequential and Annulled<=0.
- Adv=1, untaken branch without annul, or no branch: PC<=nPC, nPC<=nPC+INC, Annulled<=0.
- Consuming a branch at an Adv edge clears Pending. If Pending=1, the live BrValid is not accepted at that edge (BrReady was 0).
- Adv=0 with an accepted branch: latch Taken, Annul and Target; Pending<=1; PC, nPC and Annulled hold.
- Adv=0, no trap, no accepted branch: all state holds.
- Wrap-around: +INC beyond 2^WIDTH-1 wraps to low addresses, no flag. Target and vector alignment is not checked.
- Reset mid-operation: the asynchronous clear wins immediately, including over Trap and over a held branch.

Test Plan:
- Reset then Adv=1 for 3 cycles (RESET_PC=0) -> PC sequence 0,4,8,12; nPC = PC+4; Annulled=0.
- At PC=0x100/nPC=0x104: BrValid, BrTaken, BrTarget=0x200, Adv=1 -> PC=0x104, nPC=0x200; next Adv -> PC=0x200, nPC=0x204. With DELAYED=0 -> PC=0x200 immediately.
- Untaken annulled branch at PC=0x100 with Adv -> PC=0x104, Annulled=1; next Adv -> PC=0x108, Annulled=0.
- Adv=0 with taken branch (target 0x300) -> Pending=1, BrReady=0, PC held; second BrValid ignored; Adv -> PC=old nPC, nPC=0x300, Pending=0.
- Trap with TrapVec=0x80 while Pending=1 and Adv=1 -> PC=0x80, nPC=0x84, Pending=0, Annulled=0.
- WIDTH=8, PC=0xF8, nPC=0xFC, Adv -> PC=0xFC, nPC=0x00. Reset asserted mid-cycle between edges -> PC=RESET_PC with no clock edge.
